// File: rtl/greenhouse_actuator_sequencer.sv
// Purpose: synchronise and debounce N_CH sensor requests, then drive one actuator at a time by fixed priority.
// Latency: a held request drives its actuator DEBOUNCE+3 edges after it first changes (2 sync + DEBOUNCE + 1 FSM).
// Backpressure: none; the actuators are always ready and requests are sampled every cycle.
module greenhouse_actuator_sequencer #(
    parameter int N_CH     = 6,   // 2..16, index N_CH-1 is the emergency (gas) channel
    parameter int DEBOUNCE = 4,   // >= 1
    parameter int MIN_ON   = 16,  // >= 1
    parameter int MAX_ON   = 64,  // >= MIN_ON
    parameter int GAP_CYC  = 2    // >= 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] S,
    input  logic            emerg_ack,
    input  logic            fault_clr,
    output logic [N_CH-1:0] A,
    output logic [1:0]      state,
    output logic [3:0]      active_ch,
    output logic [N_CH-1:0] req_filt,
    output logic [N_CH-1:0] fault_mask,
    output logic            busy
);

    localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int ON_W  = $clog2(MAX_ON + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [N_CH-1:0] EMERG_BIT = {1'b1, {(N_CH-1){1'b0}}};
    localparam logic [N_CH-1:0] ONE_BIT   = {{(N_CH-1){1'b0}}, 1'b1};
    localparam logic [3:0]      EMERG_IDX = 4'(N_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GAP   = 2'd2,
        ST_EMERG = 2'd3
    } state_t;

    state_t              state_q;
    logic [N_CH-1:0]     sync1;
    logic [N_CH-1:0]     sync2;
    logic [DB_W-1:0]     db_cnt [N_CH];
    logic [ON_W-1:0]     on_cnt;
    logic [GAP_W-1:0]    gap_cnt;

    logic [N_CH-1:0]     eligible;
    logic                emerg_req;
    logic                win_any;
    logic [3:0]          win_idx;
    logic                cur_elig;

    // One-hot drive pattern for a channel index (shift avoids an index wider than the bus).
    function automatic logic [N_CH-1:0] onehot(input logic [3:0] idx);
        onehot = ONE_BIT << idx;
    endfunction

    // Two-flop synchroniser on the raw, asynchronous sensor pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= S;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce: count consecutive samples that disagree with the filtered value,
    // flip the filtered value on the DEBOUNCE-th one; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_filt <= '0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync2[i] != req_filt[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                        req_filt[i] <= sync2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // The emergency channel can never be masked, even if a stray fault bit existed.
    assign eligible  = req_filt & ~(fault_mask & ~EMERG_BIT);
    assign emerg_req = req_filt[N_CH-1];

    // In RUN, A is exactly one-hot(active_ch), so this tests whether the running request is still eligible.
    assign cur_elig  = |(eligible & A);

    // Fixed-priority pick: the highest eligible index wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (eligible[i]) begin
                win_any = 1'b1;
                win_idx = 4'(i);
            end
        end
    end

    // Sequencer FSM with registered actuator drive, active channel, timers and fault lockout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            A          <= '0;
            active_ch  <= '0;
            on_cnt     <= '0;
            gap_cnt    <= '0;
            fault_mask <= '0;
        end else begin
            // Clear takes effect next cycle; a coincident fault set below overrides it for its channel.
            if (fault_clr) begin
                fault_mask <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (emerg_req) begin
                        state_q   <= ST_EMERG;
                        A         <= EMERG_BIT;
                        active_ch <= EMERG_IDX;
                        on_cnt    <= '0;
                    end else if (win_any) begin
                        state_q   <= ST_RUN;
                        A         <= onehot(win_idx);
                        active_ch <= win_idx;
                        on_cnt    <= ON_W'(1);
                    end
                end

                ST_RUN: begin
                    if (emerg_req) begin
                        // Gas emergency pre-empts immediately, ignoring minimum on-time and the gap.
                        state_q   <= ST_EMERG;
                        A         <= EMERG_BIT;
                        active_ch <= EMERG_IDX;
                        on_cnt    <= '0;
                    end else if (on_cnt < ON_W'(MIN_ON)) begin
                        on_cnt <= on_cnt + ON_W'(1);
                    end else if ((on_cnt == ON_W'(MAX_ON)) && cur_elig) begin
                        // Stuck request: lock the channel out and open a gap.
                        fault_mask <= (fault_clr ? '0 : fault_mask) | A;
                        state_q    <= ST_GAP;
                        A          <= '0;
                        active_ch  <= '0;
                        on_cnt     <= '0;
                        gap_cnt    <= GAP_W'(1);
                    end else if (!win_any || (win_idx != active_ch)) begin
                        state_q   <= ST_GAP;
                        A         <= '0;
                        active_ch <= '0;
                        on_cnt    <= '0;
                        gap_cnt   <= GAP_W'(1);
                    end else if (on_cnt != ON_W'(MAX_ON)) begin
                        on_cnt <= on_cnt + ON_W'(1);
                    end
                end

                ST_GAP: begin
                    if (emerg_req) begin
                        state_q   <= ST_EMERG;
                        A         <= EMERG_BIT;
                        active_ch <= EMERG_IDX;
                        on_cnt    <= '0;
                    end else if (gap_cnt == GAP_W'(GAP_CYC)) begin
                        if (win_any) begin
                            state_q   <= ST_RUN;
                            A         <= onehot(win_idx);
                            active_ch <= win_idx;
                            on_cnt    <= ON_W'(1);
                        end else begin
                            state_q   <= ST_IDLE;
                            A         <= '0;
                            active_ch <= '0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                ST_EMERG: begin
                    // Latched: only an acknowledge after the gas request has cleared releases it.
                    if (!emerg_req && emerg_ack) begin
                        state_q   <= ST_GAP;
                        A         <= '0;
                        active_ch <= '0;
                        on_cnt    <= '0;
                        gap_cnt   <= GAP_W'(1);
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    A         <= '0;
                    active_ch <= '0;
                end
            endcase
        end
    end

    assign state = state_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_greenhouse_actuator_sequencer.sv
// Purpose: directed and randomized checking of greenhouse_actuator_sequencer against a behavioural model.
// Latency: model is advanced at each rising edge and compared on the following falling edge.
// Backpressure: not applicable; inputs are driven on falling edges.
module tb_greenhouse_actuator_sequencer;

    localparam int N      = 6;
    localparam int DB     = 4;
    localparam int MIN_ON = 16;
    localparam int MAX_ON = 64;
    localparam int GAP    = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] s_in = '0;
    logic         emerg_ack = 1'b0;
    logic         fault_clr = 1'b0;
    logic [N-1:0] A;
    logic [1:0]   state;
    logic [3:0]   active_ch;
    logic [N-1:0] req_filt;
    logic [N-1:0] fault_mask;
    logic         busy;

    greenhouse_actuator_sequencer #(
        .N_CH(N), .DEBOUNCE(DB), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .GAP_CYC(GAP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .S(s_in), .emerg_ack(emerg_ack), .fault_clr(fault_clr),
        .A(A), .state(state), .active_ch(active_ch), .req_filt(req_filt),
        .fault_mask(fault_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 running, 2 gap, 3 emergency.
    int           m_mode, m_ch, m_age, m_gap;
    logic [N-1:0] m_filt, m_fault;
    logic [N-1:0] hist[$];   // raw samples, newest first

    task automatic model_reset();
        m_mode = 0; m_ch = 0; m_age = 0; m_gap = 0;
        m_filt = '0; m_fault = '0;
        hist.delete();
        for (int k = 0; k < DB + 2; k++) hist.push_back('0);
    endtask

    task automatic model_step();
        logic [N-1:0] el;
        logic [N-1:0] set_bits;
        int top;
        bit em, all_diff;
        set_bits = '0;
        el = m_filt & ~m_fault;
        el[N-1] = m_filt[N-1];
        em = m_filt[N-1];
        top = -1;
        for (int i = 0; i < N; i++) if (el[i]) top = i;
        case (m_mode)
            0: begin
                if (em) begin m_mode = 3; m_ch = N - 1; end
                else if (top >= 0) begin m_mode = 1; m_ch = top; m_age = 1; end
            end
            1: begin
                if (em) begin m_mode = 3; m_ch = N - 1; end
                else if (m_age < MIN_ON) m_age++;
                else if (m_age == MAX_ON && el[m_ch]) begin
                    set_bits[m_ch] = 1'b1; m_mode = 2; m_gap = 1;
                end else if (top != m_ch) begin m_mode = 2; m_gap = 1; end
                else m_age++;
            end
            2: begin
                if (em) begin m_mode = 3; m_ch = N - 1; end
                else if (m_gap == GAP) begin
                    if (top >= 0) begin m_mode = 1; m_ch = top; m_age = 1; end
                    else m_mode = 0;
                end else m_gap++;
            end
            default: begin
                if (!m_filt[N-1] && emerg_ack) begin m_mode = 2; m_gap = 1; end
            end
        endcase
        m_fault = (fault_clr ? '0 : m_fault) | set_bits;
        // Filtered bit flips once the DB most recent synchronised samples (raw delayed by 2) all disagree.
        hist.push_front(s_in);
        for (int c = 0; c < N; c++) begin
            all_diff = 1'b1;
            for (int k = 2; k < DB + 2; k++) if (hist[k][c] == m_filt[c]) all_diff = 1'b0;
            if (all_diff) m_filt[c] = ~m_filt[c];
        end
        while (hist.size() > DB + 2) void'(hist.pop_back());
    endtask

    task automatic compare_all();
        logic [N-1:0] ea;
        int ech;
        ea  = (m_mode == 1 || m_mode == 3) ? (N'(1) << m_ch) : '0;
        ech = (m_mode == 1 || m_mode == 3) ? m_ch : 0;
        chk("A", A, ea);
        chk("state", state, m_mode);
        chk("active_ch", active_ch, ech);
        chk("req_filt", req_filt, m_filt);
        chk("fault_mask", fault_mask, m_fault);
        chk("busy", busy, m_mode != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset(); else model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_a(input logic [N-1:0] val, input int bound, input string tag);
        int n = 0;
        while (A !== val && n < bound) begin tick(); n++; end
        chk(tag, A, val);
    endtask

    // Counts cycles A stays at val (first one already observed); returns with A at its next value.
    task automatic on_len(input logic [N-1:0] val, input int start, output int n);
        n = start;
        while (n < 300) begin
            tick();
            if (A !== val) break;
            n++;
        end
    endtask

    task automatic settle(input string tag);
        int n = 0;
        s_in = '0;
        while (state !== 2'd0 && n < 300) begin tick(); n++; end
        chk(tag, state, 0);
    endtask

    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        chk({tag, "_A"}, A, 0);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_fault"}, fault_mask, 0);
        chk({tag, "_busy"}, busy, 0);
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int n, z, hold;
        logic [N-1:0] v;
        model_reset();
        tick();
        tick();
        chk("rst_A", A, 0);
        chk("rst_filt", req_filt, 0);
        reset_n = 1'b1;
        tick();

        // Latency: A appears exactly on the 7th edge after the request changes.
        s_in = 6'b000100;
        repeat (6) tick();
        chk("lat_early", A, 6'b000000);
        tick();
        chk("lat_A", A, 6'b000100);
        chk("lat_state", state, 1);
        chk("lat_ch", active_ch, 2);
        chk("lat_busy", busy, 1);
        settle("settle1");

        // A pulse shorter than the debounce window is rejected.
        s_in = 6'b000001;
        repeat (3) tick();
        s_in = '0;
        repeat (8) begin
            tick();
            chk("glitch_filt", req_filt, 0);
            chk("glitch_state", state, 0);
        end

        // Higher request arriving early waits for MIN_ON, then a GAP-cycle gap.
        s_in = 6'b000010;
        wait_a(6'b000010, 20, "pre_rise");
        repeat (3) tick();
        s_in = 6'b001010;
        on_len(6'b000010, 4, n);
        chk("pre_on_len", n, MIN_ON);
        z = 0;
        while (A === '0 && z < 20) begin z++; tick(); end
        chk("pre_gap_len", z, GAP);
        chk("pre_next", A, 6'b001000);
        settle("settle2");

        // Stuck request: MAX_ON then lockout, clear re-arms it.
        s_in = 6'b000100;
        wait_a(6'b000100, 20, "max_rise");
        on_len(6'b000100, 1, n);
        chk("max_on_len", n, MAX_ON);
        chk("max_fault", fault_mask, 6'b000100);
        chk("max_state_gap", state, 2);
        tick();
        tick();
        chk("max_state_idle", state, 0);
        repeat (3) tick();
        chk("max_locked_A", A, 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr_fault", fault_mask, 0);
        wait_a(6'b000100, 10, "clr_rearm");
        settle("settle3");

        // Emergency pre-empts mid-MIN_ON with no gap; latch needs ack after request clears.
        s_in = 6'b000010;
        wait_a(6'b000010, 20, "em_rise");
        repeat (4) tick();
        s_in = 6'b100010;
        on_len(6'b000010, 5, n);
        chk("em_nogap", A, 6'b100000);
        chk("em_state", state, 3);
        emerg_ack = 1'b1;
        tick();
        emerg_ack = 1'b0;
        repeat (2) tick();
        chk("em_ack_ignored", state, 3);
        s_in = '0;
        repeat (10) tick();
        chk("em_latched", state, 3);
        chk("em_latched_A", A, 6'b100000);
        emerg_ack = 1'b1;
        tick();
        emerg_ack = 1'b0;
        chk("em_exit_gap", state, 2);
        tick();
        tick();
        chk("em_exit_idle", state, 0);

        // Asynchronous reset during EMERG and during GAP (with a fault set).
        s_in = 6'b100000;
        wait_a(6'b100000, 20, "rst_em_rise");
        async_reset("rst_em");
        s_in = 6'b000001;
        wait_a(6'b000001, 20, "rst_gap_rise");
        on_len(6'b000001, 1, n);
        chk("rst_gap_state", state, 2);
        chk("rst_gap_fault", fault_mask, 6'b000001);
        async_reset("rst_gap");
        s_in = '0;
        repeat (4) tick();

        // Randomized traffic against the model.
        for (int seg = 0; seg < 40; seg++) begin
            v = N'($urandom);
            if ($urandom_range(0, 3) != 0) v[N-1] = 1'b0;
            s_in = v;
            hold = $urandom_range(1, 60);
            for (int t = 0; t < hold; t++) begin
                emerg_ack = ($urandom_range(0, 5) == 0);
                fault_clr = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 19) == 0) s_in[$urandom_range(0, N - 1)] ^= 1'b1;
                tick();
            end
        end
        emerg_ack = 1'b0;
        fault_clr = 1'b0;
        s_in = '0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/greenhouse_actuator_sequencer.md
Name: greenhouse_actuator_sequencer

Overview:
Parametrised successor to the six-channel greenhouse priority FSM. It takes N_CH raw sensor requests and synchronises and debounces each one. It drives exactly one actuator at a time by fixed priority, with minimum on-time, maximum on-time fault lockout, break-before-make gaps and a latching emergency channel. It sits between the sensor input pins and the actuator drivers and status LEDs of the greenhouse controller.

Parameters:
N_CH, 6, number of sensor/actuator channels (2..16); index N_CH-1 is the emergency (gas) channel; higher index = higher priority
DEBOUNCE, 4, consecutive stable synchronised cycles before a filtered request changes (>=1)
MIN_ON, 16, minimum cycles an actuator stays on once started (>=1)
MAX_ON, 64, maximum continuous on cycles for non-emergency channels before fault lockout (>=MIN_ON)
GAP_CYC, 2, all-off cycles between deactivation and next activation (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
S  in  N_CH  raw asynchronous sensor requests, active high
emerg_ack  in  1  single-cycle operator acknowledge that releases the emergency latch
fault_clr  in  1  single-cycle pulse that clears all fault_mask bits
A  out  N_CH  actuator drive, one-hot or zero, registered
state  out  2  FSM state: 0 IDLE, 1 RUN, 2 GAP, 3 EMERG
active_ch  out  4  index of the channel driven in RUN/EMERG; 0 otherwise
req_filt  out  N_CH  debounced requests, for status display
fault_mask  out  N_CH  channels locked out after MAX_ON timeout
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset is asynchronous and active-low; clock is clk. On reset: A=0, state=IDLE, active_ch=0, req_filt=0, fault_mask=0, all counters and synchronisers 0. Reset asserted mid-operation clears A immediately, without waiting for a clock.
- Input path, per channel: 2-FF synchroniser, then debounce counter. req_filt[i] toggles only after the synchronised value differs from req_filt[i] for DEBOUNCE consecutive cycles. Any glitch restarts the count.
- Eligible set: req_filt & ~fault_mask. The emergency bit is never maskable. Winner is the highest set index.
- IDLE: A=0. If emergency is eligible, go to EMERG. Otherwise, if any channel is eligible, go to RUN with the winner, A=one-hot(winner) and on_cnt=1.
- Latency in IDLE, with S stable from edge k: A is valid after edge k+DEBOUNCE+3.
- RUN: on_cnt increments each cycle and saturates at MAX_ON.
  - Emergency eligible: go to EMERG at the next edge with no gap. Emergency overrides MIN_ON.
  - on_cnt < MIN_ON: hold the current channel, even if its request dropped or a higher one arrived.
  - on_cnt >= MIN_ON and the winner differs from active_ch (including none): go to GAP.
  - on_cnt == MAX_ON and the current request is still eligible: set fault_mask[active_ch] and go to GAP.
- GAP: A=0, counts GAP_CYC cycles. Emergency eligible during GAP: go to EMERG immediately. At end of the gap: go to RUN with the winner (on_cnt=1), or to IDLE if none is eligible.
- EMERG: A=one-hot(N_CH-1), with no MAX_ON limit. The state is latched. Exit to GAP only in a cycle where req_filt[N_CH-1]=0 and emerg_ack=1. An emerg_ack while the emergency request is still high is ignored and not remembered.
- fault_clr clears fault_mask the following cycle. If fault_clr coincides with a fault set, the set wins for that channel.
- A changes only on clock edges and is never multi-hot. Every transition between two different active channels passes through at least GAP_CYC zero cycles, except entry into EMERG.
- active_ch is zero-extended; for N_CH>16 the parameter is illegal.

Test Plan:
- Reset, then S=6'b000100 held: A=6'b000100 exactly 7 cycles after the input edge; state=RUN; active_ch=2; busy=1.
- 3-cycle pulse on S[0] (less than DEBOUNCE): req_filt and A stay 0, state stays IDLE.
- S[1] active, then S[3] asserted 3 cycles after A[1] rises: A[1] stays on until on_cnt=16, then 2 cycles of A=0, then A=6'b001000.
- S[2] held continuously: A[2] is on for exactly 64 cycles, then fault_mask=6'b000100, A=0 and state goes GAP→IDLE. A fault_clr pulse re-arms the channel: RUN restarts after GAP.
- Mid-RUN on channel 1 with on_cnt=5, S[5] rises: A=6'b100000 after debounce with no gap. S[5] dropped but no ack: stays EMERG. Ack while S[5]=1: ignored. Ack after req_filt[5]=0: GAP then IDLE.
- reset_n pulsed low during EMERG and again during GAP: A=0 and state=IDLE asynchronously, and fault_mask is cleared.
